// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds FSM state encoding, control bundle and bundle presets.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_bubble;
        logic idex_bubble;
        logic exmem_bubble;
    } ctrl_t;

    function automatic ctrl_t ctrl_pass();
        ctrl_t c;
        c = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
              exmem_we: 1'b1, memwb_we: 1'b1,
              ifid_bubble: 1'b0, idex_bubble: 1'b0,
              exmem_bubble: 1'b0};
        return c;
    endfunction

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
              exmem_we: 1'b0, memwb_we: 1'b0,
              ifid_bubble: 1'b1, idex_bubble: 1'b1,
              exmem_bubble: 1'b1};
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
// Ports: clk, rst (async high), inc, clr -> cnt[W-1:0].
module pipe_hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Ports: ID/EX hazard info, md_done, cnt_clr in; register
// write enables, bubbles, md_start, md_error, perf counters out.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_we,
    input  logic              ex_mem_read,
    input  logic              ex_br_taken,
    input  logic              ex_md_op,
    input  logic              md_done,
    input  logic              cnt_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_bubble,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              md_start,
    output logic              md_error,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WD_W = $clog2(MD_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    ctrl_t           ctrl;
    logic [WD_W-1:0] wd;
    logic            timeout;
    logic            load_use;
    logic            br_flush;

    // Release happens in the MD_TIMEOUT-th wait cycle.
    assign timeout = (state == MD_WAIT) &&
                     (wd == WD_W'(MD_TIMEOUT - 1));

    assign load_use = ex_mem_read && ex_rd_we &&
                      (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        ctrl      = ctrl_pass();
        state_nxt = state;
        br_flush  = 1'b0;
        if (rst) begin
            ctrl      = ctrl_reset();
            state_nxt = RUN;
        end else if (((state == RUN) && ex_md_op) ||
                     ((state == MD_WAIT) && !md_done && !timeout)) begin
            // Hold front end; drain a bubble into MEM.
            ctrl.pc_we        = 1'b0;
            ctrl.ifid_we      = 1'b0;
            ctrl.idex_we      = 1'b0;
            ctrl.exmem_bubble = 1'b1;
            state_nxt         = MD_WAIT;
        end else if (state == MD_WAIT) begin
            state_nxt = RUN;
        end else if (ex_br_taken) begin
            // Squashes the ID instruction, so load-use is moot.
            ctrl.ifid_bubble = 1'b1;
            ctrl.idex_bubble = 1'b1;
            br_flush         = 1'b1;
        end else if (load_use) begin
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            md_start <= 1'b0;
            md_error <= 1'b0;
            wd       <= '0;
        end else begin
            state    <= state_nxt;
            md_start <= (state == RUN) && ex_md_op;
            if (timeout && !md_done) begin
                md_error <= 1'b1;
            end
            if (state == RUN) begin
                wd <= '0;
            end else begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign ifid_we      = ctrl.ifid_we;
    assign idex_we      = ctrl.idex_we;
    assign exmem_we     = ctrl.exmem_we;
    assign memwb_we     = ctrl.memwb_we;
    assign ifid_bubble  = ctrl.ifid_bubble;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_bubble = ctrl.exmem_bubble;

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!ctrl.pc_we && !rst),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_flush),
        .clr (cnt_clr),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a uses defaults,
// instance b uses MD_TIMEOUT=4, CNT_W=2 for watchdog/saturation.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_rd_we, ex_mem_read, ex_br_taken;
    logic       ex_md_op, md_done, md_op_b, md_done_b;
    logic       cnt_clr;

    logic        pc_we_a, ifid_we_a, idex_we_a, exmem_we_a, memwb_we_a;
    logic        ifid_bub_a, idex_bub_a, exmem_bub_a;
    logic        md_start_a, md_error_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;

    logic        pc_we_b, ifid_we_b, idex_we_b, exmem_we_b, memwb_we_b;
    logic        ifid_bub_b, idex_bub_b, exmem_bub_b;
    logic        md_start_b, md_error_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {pc_we_a, ifid_we_a, idex_we_a, exmem_we_a,
                    memwb_we_a, ifid_bub_a, idex_bub_a, exmem_bub_a};
    assign ctl_b = {pc_we_b, ifid_we_b, idex_we_b, exmem_we_b,
                    memwb_we_b, ifid_bub_b, idex_bub_b, exmem_bub_b};

    // {pc,ifid,idex,exmem,memwb we ; ifid,idex,exmem bubble}
    localparam logic [7:0] C_PASS = 8'b11111_000;
    localparam logic [7:0] C_RST  = 8'b00000_111;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_MD   = 8'b00011_001;

    int checks;
    int failures;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .ex_md_op(ex_md_op), .md_done(md_done), .cnt_clr(cnt_clr),
        .pc_we(pc_we_a), .ifid_we(ifid_we_a), .idex_we(idex_we_a),
        .exmem_we(exmem_we_a), .memwb_we(memwb_we_a),
        .ifid_bubble(ifid_bub_a), .idex_bubble(idex_bub_a),
        .exmem_bubble(exmem_bub_a),
        .md_start(md_start_a), .md_error(md_error_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .ex_md_op(md_op_b), .md_done(md_done_b), .cnt_clr(cnt_clr),
        .pc_we(pc_we_b), .ifid_we(ifid_we_b), .idex_we(idex_we_b),
        .exmem_we(exmem_we_b), .memwb_we(memwb_we_b),
        .ifid_bubble(ifid_bub_b), .idex_bubble(idex_bub_b),
        .exmem_bubble(exmem_bub_b),
        .md_start(md_start_b), .md_error(md_error_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hz();
        id_rs1      = '0;
        id_rs2      = '0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_rd       = '0;
        ex_rd_we    = 1'b0;
        ex_mem_read = 1'b0;
        ex_br_taken = 1'b0;
    endtask

    task automatic set_load_hit();
        ex_mem_read = 1'b1;
        ex_rd_we    = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd3;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd5;
        id_rs2_used = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ex_md_op  = 1'b0;
        md_done   = 1'b0;
        md_op_b   = 1'b0;
        md_done_b = 1'b0;
        cnt_clr   = 1'b0;
        clear_hz();

        // Reset state
        #2;
        chk("rst_ctl_a", 32'(ctl_a), 32'(C_RST));
        chk("rst_ctl_b", 32'(ctl_b), 32'(C_RST));
        chk("rst_stall", 32'(stall_cnt_a), 0);
        chk("rst_mdstart", 32'(md_start_a), 0);
        chk("rst_mderr", 32'(md_error_a), 0);
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("idle_ctl", 32'(ctl_a), 32'(C_PASS));

        // Load x5 in EX, ID reads x5 via rs2
        set_load_hit();
        #2;
        chk("lu_ctl", 32'(ctl_a), 32'(C_LU));
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt_a), 1);
        clear_hz();
        #2;
        chk("lu_after", 32'(ctl_a), 32'(C_PASS));

        // Load to x0 never stalls
        ex_mem_read = 1'b1;
        ex_rd_we    = 1'b1;
        id_rs1_used = 1'b1;
        #2;
        chk("x0_ctl", 32'(ctl_a), 32'(C_PASS));
        tick();
        chk("x0_stall_cnt", 32'(stall_cnt_a), 1);

        // Taken branch overrides load-use hit
        ex_rd       = 5'd7;
        id_rs1      = 5'd7;
        ex_br_taken = 1'b1;
        #2;
        chk("br_ctl", 32'(ctl_a), 32'(C_BR));
        tick();
        chk("br_flush_cnt", 32'(flush_cnt_a), 1);
        chk("br_stall_cnt", 32'(stall_cnt_a), 1);
        clear_hz();

        // MUL/DIV with done 5 cycles after md_start
        ex_md_op = 1'b1;
        #2;
        chk("md_run_ctl", 32'(ctl_a), 32'(C_MD));
        tick();
        chk("md_start_pulse", 32'(md_start_a), 1);
        chk("md_w1_ctl", 32'(ctl_a), 32'(C_MD));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("md_start_low", 32'(md_start_a), 0);
            chk("md_wait_ctl", 32'(ctl_a), 32'(C_MD));
        end
        tick();
        md_done = 1'b1;
        #2;
        chk("md_done_ctl", 32'(ctl_a), 32'(C_PASS));
        tick();
        md_done  = 1'b0;
        ex_md_op = 1'b0;
        chk("md_stall_cnt", 32'(stall_cnt_a), 7);
        chk("md_no_err", 32'(md_error_a), 0);

        // md_done in RUN is ignored
        md_done = 1'b1;
        #2;
        chk("done_run_ctl", 32'(ctl_a), 32'(C_PASS));
        tick();
        md_done = 1'b0;
        chk("done_run_start", 32'(md_start_a), 0);

        // Watchdog on instance b (MD_TIMEOUT=4)
        md_op_b = 1'b1;
        #2;
        chk("wd_run_ctl", 32'(ctl_b), 32'(C_MD));
        tick();
        chk("wd_start", 32'(md_start_b), 1);
        tick();
        chk("wd_w2_ctl", 32'(ctl_b), 32'(C_MD));
        tick();
        chk("wd_w3_ctl", 32'(ctl_b), 32'(C_MD));
        chk("wd_w3_err", 32'(md_error_b), 0);
        tick();
        chk("wd_release", 32'(ctl_b), 32'(C_PASS));
        tick();
        md_op_b = 1'b0;
        chk("wd_err_set", 32'(md_error_b), 1);
        tick();
        tick();
        chk("wd_err_sticky", 32'(md_error_b), 1);
        chk("wd_after_ctl", 32'(ctl_b), 32'(C_PASS));
        chk("wd_a_clean", 32'(md_error_a), 0);

        // Clear wins over a simultaneous increment
        set_load_hit();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        clear_hz();
        chk("clr_stall_a", 32'(stall_cnt_a), 0);
        chk("clr_stall_b", 32'(stall_cnt_b), 0);
        chk("clr_flush_a", 32'(flush_cnt_a), 0);

        // 5 load-use stalls saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            set_load_hit();
            tick();
            clear_hz();
            tick();
        end
        chk("sat_stall_b", 32'(stall_cnt_b), 3);
        chk("sat_stall_a", 32'(stall_cnt_a), 5);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr_b", 32'(stall_cnt_b), 0);

        // Reset in the middle of MD_WAIT
        md_op_b = 1'b1;
        tick();
        chk("mid_start", 32'(md_start_b), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_start", 32'(md_start_b), 0);
        chk("mid_rst_ctl", 32'(ctl_b), 32'(C_RST));
        chk("mid_rst_err", 32'(md_error_b), 0);
        tick();
        rst     = 1'b0;
        md_op_b = 1'b0;
        #2;
        chk("mid_run_ctl", 32'(ctl_b), 32'(C_PASS));
        tick();
        chk("mid_no_start", 32'(md_start_b), 0);
        chk("mid_no_err", 32'(md_error_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
